// File: rtl/l2_responder_pkg.sv
// Shared constants for the L2 responder: request encodings, FSM states
// and the layout of a queued request entry.
package l2_responder_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  function automatic int line_w(int dw, int words);
    return dw * words;
  endfunction

  // Entry packs as {line index, rw, id, line data}, data at bit 0.
  function automatic int ent_id_lsb(int lw);
    return lw;
  endfunction

  function automatic int ent_rw_bit(int lw, int idw);
    return lw + idw;
  endfunction

  function automatic int ent_idx_lsb(int lw, int idw);
    return lw + idw + 1;
  endfunction

  function automatic int ent_w(int lw, int idw, int ixw);
    return lw + idw + 1 + ixw;
  endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// In-order request queue; pointers carry one extra bit so that
// full and empty are distinguishable without a separate counter.
module l2_req_fifo
  import l2_responder_pkg::*;
#(
  parameter int EW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [EW-1:0] i_data,
  input  logic          i_pop,
  output logic [EW-1:0] o_head,
  output logic          o_empty,
  output logic          o_full,
  output logic [PW-1:0] o_occ
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          w_push;
  logic          w_pop;

  assign o_occ   = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_occ == PW'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/l2_responder.sv
// Memory side of the L1 miss/writeback port: queues line requests and
// serves them from a line-wide store after a fixed access latency.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS          = 8,
  parameter int LINE_BITS      = 5,
  parameter int MEM_INDEX_BITS = 10,
  parameter int MSHR_ID_BITS   = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int LATENCY        = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_WIDTH-1:0]               l1_addr_i,
  input  logic [line_w(DATA_WIDTH,WORDS)-1:0] l1_data_i,
  input  logic                                l1_rw_i,
  input  logic                                l1_valid_i,
  input  logic [MSHR_ID_BITS-1:0]             l1_id_i,
  output logic                                l1_stall_o,
  output logic [line_w(DATA_WIDTH,WORDS)-1:0] l1_data_o,
  output logic                                l1_valid_o,
  output logic [MSHR_ID_BITS-1:0]             l1_id_o
);

  localparam int LW     = line_w(DATA_WIDTH, WORDS);
  localparam int IXW    = MEM_INDEX_BITS;
  localparam int EW     = ent_w(LW, MSHR_ID_BITS, IXW);
  localparam int ID_LSB = ent_id_lsb(LW);
  localparam int RW_BIT = ent_rw_bit(LW, MSHR_ID_BITS);
  localparam int IX_LSB = ent_idx_lsb(LW, MSHR_ID_BITS);
  localparam int PW     = $clog2(QUEUE_DEPTH) + 1;
  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [ADDR_WIDTH-1:0]   w_unused_addr;
  logic [IXW-1:0]          w_req_idx;
  logic [EW-1:0]           w_req_ent;
  logic [EW-1:0]           w_head;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push_ok;
  logic                    w_done;
  logic [PW-1:0]           w_occ;
  logic [PW-1:0]           w_occ_nxt;

  logic [0:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [IXW-1:0]          r_idx;
  logic                    r_rw;
  logic [MSHR_ID_BITS-1:0] r_id;
  logic [LW-1:0]           r_wdata;
  logic                    r_stall;
  logic                    r_drop_err;
  logic [LW-1:0]           r_store [2**IXW];

  assign w_unused_addr = l1_addr_i;
  assign w_req_idx = l1_addr_i[LINE_BITS+IXW-1:LINE_BITS];
  assign w_req_ent = {w_req_idx, l1_rw_i, l1_id_i, l1_data_i};

  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_push_ok = l1_valid_i && !w_full;
  assign w_occ_nxt = w_occ + PW'(w_push_ok) - PW'(w_pop);
  assign w_done    = (r_state == ST_ACCESS) && (r_cnt == '0);

  assign l1_stall_o = r_stall;

  l2_req_fifo #(
    .EW    (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (l1_valid_i),
    .i_data  (w_req_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_occ   (w_occ)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rw       <= RW_READ;
      r_id       <= '0;
      r_wdata    <= '0;
      r_stall    <= 1'b0;
      r_drop_err <= 1'b0;
      l1_valid_o <= 1'b0;
      l1_data_o  <= '0;
      l1_id_o    <= '0;
    end else begin
      l1_valid_o <= 1'b0;
      // One entry of slack covers the L1's registered view of stall.
      r_stall    <= (w_occ_nxt >= PW'(QUEUE_DEPTH - 1));
      r_drop_err <= r_drop_err | (l1_valid_i && w_full);
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_idx   <= w_head[IX_LSB +: IXW];
            r_rw    <= w_head[RW_BIT];
            r_id    <= w_head[ID_LSB +: MSHR_ID_BITS];
            r_wdata <= w_head[LW-1:0];
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            if (r_rw == RW_READ) begin
              l1_data_o  <= r_store[r_idx];
              l1_id_o    <= r_id;
              l1_valid_o <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_done && (r_rw == RW_WRITE)) r_store[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_l2_responder.sv
// Self-checking bench for l2_responder: directed scenarios plus a
// randomized stream checked against a timestamp-based queue model.
module tb_l2_responder;
  import l2_responder_pkg::*;

  localparam int LW  = 256;
  localparam int LAT = 4;
  localparam int QD  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   l1_addr_i = '0;
  logic [LW-1:0] l1_data_i = '0;
  logic          l1_rw_i = 1'b0;
  logic          l1_valid_i = 1'b0;
  logic [3:0]    l1_id_i = '0;
  logic          l1_stall_o;
  logic [LW-1:0] l1_data_o;
  logic          l1_valid_o;
  logic [3:0]    l1_id_o;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS(8),
    .LINE_BITS(5), .MEM_INDEX_BITS(10), .MSHR_ID_BITS(4),
    .QUEUE_DEPTH(QD), .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .l1_addr_i  (l1_addr_i),
    .l1_data_i  (l1_data_i),
    .l1_rw_i    (l1_rw_i),
    .l1_valid_i (l1_valid_i),
    .l1_id_i    (l1_id_i),
    .l1_stall_o (l1_stall_o),
    .l1_data_o  (l1_data_o),
    .l1_valid_o (l1_valid_o),
    .l1_id_o    (l1_id_o)
  );

  // Reference model: each accepted request gets a pop edge and a
  // completion edge; service is serial, LATENCY+1 edges per request.
  typedef struct {
    logic          rw;
    int            idx;
    int            id;
    logic [LW-1:0] data;
    int            pop_e;
    int            resp_e;
  } mreq_t;

  mreq_t         m_q[$];
  mreq_t         m_r;
  logic [LW-1:0] m_mem [int];
  int            m_cyc = 0;
  int            m_last_pop = -100;
  int            m_before = 0;
  int            m_occ = 0;
  logic          m_valid = 1'b0;
  logic          m_stall = 1'b0;
  logic          m_known = 1'b0;
  logic [3:0]    m_id = '0;
  logic [LW-1:0] m_data = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_last_pop = -100;
      m_valid = 1'b0;
      m_stall = 1'b0;
      m_id = '0;
      m_data = '0;
      m_occ = 0;
    end else begin
      m_cyc++;
      m_before = 0;
      foreach (m_q[i]) if (m_q[i].pop_e >= m_cyc) m_before++;
      m_valid = 1'b0;
      if (m_q.size() > 0 && m_q[0].resp_e == m_cyc) begin
        m_r = m_q.pop_front();
        if (m_r.rw == RW_WRITE) begin
          m_mem[m_r.idx] = m_r.data;
        end else begin
          m_valid = 1'b1;
          m_id = 4'(m_r.id);
          m_known = m_mem.exists(m_r.idx);
          if (m_known) m_data = m_mem[m_r.idx];
        end
      end
      if (l1_valid_i && m_before < QD) begin
        m_r.rw = l1_rw_i;
        m_r.idx = int'(l1_addr_i[14:5]);
        m_r.id = int'(l1_id_i);
        m_r.data = l1_data_i;
        m_r.pop_e = m_cyc + 1;
        if (m_last_pop + LAT + 1 > m_r.pop_e)
          m_r.pop_e = m_last_pop + LAT + 1;
        m_r.resp_e = m_r.pop_e + LAT;
        m_last_pop = m_r.pop_e;
        m_q.push_back(m_r);
      end
      m_occ = 0;
      foreach (m_q[i]) if (m_q[i].pop_e > m_cyc) m_occ++;
      m_stall = (m_occ >= QD - 1);
    end
  end

  int            rc_cyc[$];
  logic [3:0]    rc_id[$];
  logic [LW-1:0] rc_data[$];
  int            occ_max = 0;

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one cycle of request inputs and record any response seen.
  task automatic step(input logic v, input logic rw,
                      input logic [31:0] a, input logic [LW-1:0] d,
                      input logic [3:0] id);
    l1_valid_i = v;
    l1_rw_i = rw;
    l1_addr_i = a;
    l1_data_i = d;
    l1_id_i = id;
    @(negedge clk);
    if (int'(dut.w_occ) > occ_max) occ_max = int'(dut.w_occ);
    if (l1_valid_o) begin
      rc_cyc.push_back(m_cyc);
      rc_id.push_back(l1_id_o);
      rc_data.push_back(l1_data_o);
    end
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, RW_READ, '0, '0, '0);
  endtask

  task automatic clear_rc();
    rc_cyc.delete();
    rc_id.delete();
    rc_data.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 4;
    if (l1_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid: got %b want 0", l1_valid_o);
    end
    if (l1_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall: got %b want 0", l1_stall_o);
    end
    if (l1_id_o !== 4'h0) begin
      n_fail++; $display("FAIL rst_id: got %h want 0", l1_id_o);
    end
    if (l1_data_o !== '0) begin
      n_fail++; $display("FAIL rst_data: got %h want 0", l1_data_o);
    end
    reset = 1'b1;
    run_idle(2);
    n_tests++;
    if (l1_valid_o !== 1'b0 || l1_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst: got v=%b s=%b want 0 0",
               l1_valid_o, l1_stall_o);
    end
  endtask

  task automatic test_write_read();
    logic [LW-1:0] wl;
    int e0;
    int got;
    for (int i = 0; i < 8; i++) wl[i*32 +: 32] = 32'h1111_0000 + i;
    clear_rc();
    step(1'b1, RW_WRITE, 32'h0000_0040, wl, 4'd2);
    run_idle(8);
    n_tests++;
    if (rc_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL wr_no_resp: got %0d responses want 0", rc_cyc.size());
    end
    clear_rc();
    e0 = m_cyc + 1;
    step(1'b1, RW_READ, 32'h0000_0044, '0, 4'd9);
    run_idle(12);
    got = (rc_cyc.size() > 0) ? rc_cyc[0] : -1;
    n_tests += 4;
    if (rc_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL rd_count: got %0d responses want 1", rc_cyc.size());
    end
    if (got != e0 + LAT + 1) begin
      n_fail++;
      $display("FAIL rd_latency: got edge %0d want %0d", got, e0 + LAT + 1);
    end
    if (rc_id.size() == 0 || rc_id[0] !== 4'd9) begin
      n_fail++; $display("FAIL rd_id: want 9");
    end
    if (rc_data.size() == 0 || rc_data[0] !== wl) begin
      n_fail++; $display("FAIL rd_data: want %h", wl);
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] la;
    logic [LW-1:0] lb;
    la = rline();
    lb = rline();
    step(1'b1, RW_WRITE, 32'h0000_0080, la, 4'd0);
    step(1'b1, RW_WRITE, 32'h0000_00A0, lb, 4'd0);
    run_idle(14);
    clear_rc();
    step(1'b1, RW_READ, 32'h0000_0080, '0, 4'd3);
    step(1'b1, RW_READ, 32'h0000_00A0, '0, 4'd5);
    run_idle(16);
    n_tests++;
    if (rc_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", rc_cyc.size());
    end else begin
      n_tests += 3;
      if (rc_id[0] !== 4'd3 || rc_id[1] !== 4'd5) begin
        n_fail++;
        $display("FAIL b2b_order: got %0d,%0d want 3,5", rc_id[0], rc_id[1]);
      end
      if (rc_cyc[1] - rc_cyc[0] != LAT + 1) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d want %0d",
                 rc_cyc[1] - rc_cyc[0], LAT + 1);
      end
      if (rc_data[0] !== la || rc_data[1] !== lb) begin
        n_fail++; $display("FAIL b2b_data: got %h want %h", rc_data[0], la);
      end
    end
  endtask

  task automatic test_alias();
    logic [LW-1:0] lc;
    lc = rline();
    step(1'b1, RW_WRITE, 32'h0000_8040, lc, 4'd1);
    run_idle(8);
    clear_rc();
    step(1'b1, RW_READ, 32'h0000_0040, '0, 4'hA);
    run_idle(10);
    n_tests++;
    if (rc_data.size() != 1 || rc_data[0] !== lc || rc_id[0] !== 4'hA) begin
      n_fail++;
      $display("FAIL alias: got %0d responses want 1 with id a data %h",
               rc_data.size(), lc);
    end
  endtask

  task automatic test_overflow();
    logic [LW-1:0] la;
    la = rline();
    occ_max = 0;
    step(1'b1, RW_WRITE, 32'd20 << 5, la, 4'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, RW_WRITE, (32'd21 + i) << 5, rline(), 4'd1);
      n_tests++;
      if (l1_stall_o !== m_stall) begin
        n_fail++;
        $display("FAIL ovf_stall%0d: got %b want %b", i, l1_stall_o, m_stall);
      end
    end
    step(1'b1, RW_WRITE, 32'd20 << 5, rline(), 4'd1);
    n_tests += 2;
    if (l1_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_stall_full: got %b want 1", l1_stall_o);
    end
    if (dut.r_drop_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %b want 1", dut.r_drop_err);
    end
    for (int k = 0; k < 24; k++) begin
      run_idle(1);
      n_tests++;
      if (l1_stall_o !== m_stall) begin
        n_fail++;
        $display("FAIL ovf_drain_stall: got %b want %b", l1_stall_o, m_stall);
      end
    end
    n_tests++;
    if (occ_max > QD) begin
      n_fail++; $display("FAIL ovf_occ: got %0d want <= %0d", occ_max, QD);
    end
    clear_rc();
    step(1'b1, RW_READ, 32'd20 << 5, '0, 4'd6);
    run_idle(10);
    n_tests++;
    if (rc_data.size() != 1 || rc_data[0] !== la) begin
      n_fail++; $display("FAIL ovf_dropped_kept_out: want %h", la);
    end
  endtask

  task automatic test_simul();
    logic [LW-1:0] l0;
    logic [LW-1:0] l3;
    l0 = rline();
    l3 = rline();
    step(1'b1, RW_WRITE, 32'd40 << 5, l0, 4'd1);
    step(1'b1, RW_WRITE, 32'd41 << 5, rline(), 4'd1);
    step(1'b1, RW_WRITE, 32'd42 << 5, rline(), 4'd1);
    step(1'b1, RW_WRITE, 32'd43 << 5, l3, 4'd1);
    run_idle(2);
    n_tests += 2;
    if (l1_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL simul_stall_pre: got %b want 1", l1_stall_o);
    end
    if (int'(dut.w_occ) != 3) begin
      n_fail++; $display("FAIL simul_occ_pre: got %0d want 3", dut.w_occ);
    end
    clear_rc();
    step(1'b1, RW_READ, 32'd40 << 5, '0, 4'd11);
    n_tests += 2;
    if (l1_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL simul_stall: got %b want 1", l1_stall_o);
    end
    if (int'(dut.w_occ) != 3) begin
      n_fail++; $display("FAIL simul_occ: got %0d want 3", dut.w_occ);
    end
    run_idle(24);
    step(1'b1, RW_READ, 32'd43 << 5, '0, 4'd12);
    run_idle(10);
    n_tests++;
    if (rc_id.size() != 2 || rc_id[0] !== 4'd11 || rc_data[0] !== l0 ||
        rc_id[1] !== 4'd12 || rc_data[1] !== l3) begin
      n_fail++;
      $display("FAIL simul_lost: got %0d responses want 2 (ids 11,12)",
               rc_id.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] ld;
    ld = rline();
    step(1'b1, RW_WRITE, 32'd30 << 5, ld, 4'd1);
    run_idle(8);
    clear_rc();
    step(1'b1, RW_READ, 32'd30 << 5, '0, 4'd7);
    step(1'b1, RW_WRITE, 32'd30 << 5, rline(), 4'd8);
    step(1'b1, RW_READ, 32'd30 << 5, '0, 4'd9);
    l1_valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests += 3;
    if (l1_valid_o !== 1'b0 || l1_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctl: got v=%b s=%b want 0 0",
               l1_valid_o, l1_stall_o);
    end
    if (l1_data_o !== '0) begin
      n_fail++; $display("FAIL mid_rst_data: got %h want 0", l1_data_o);
    end
    if (l1_id_o !== 4'h0) begin
      n_fail++; $display("FAIL mid_rst_id: got %h want 0", l1_id_o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_idle(16);
    n_tests += 2;
    if (rc_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL mid_rst_resp: got %0d responses want 0", rc_cyc.size());
    end
    if (l1_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_stall: got %b want 0", l1_stall_o);
    end
    step(1'b1, RW_READ, 32'd30 << 5, '0, 4'd10);
    run_idle(10);
    n_tests++;
    if (rc_data.size() != 1 || rc_data[0] !== ld) begin
      n_fail++; $display("FAIL mid_rst_nowrite: want %h", ld);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [9:0]  ix;
    for (int k = 0; k < 440; k++) begin
      l1_valid_i = 1'b0;
      if (k < 400 && !l1_stall_o && $urandom_range(0, 2) != 0) begin
        a = $urandom;
        ix = 10'($urandom_range(0, 7));
        a[14:5] = ix;
        l1_valid_i = 1'b1;
        l1_rw_i = 1'($urandom_range(0, 1));
        l1_addr_i = a;
        l1_data_i = rline();
        l1_id_i = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      n_tests += 2;
      if (l1_valid_o !== m_valid) begin
        n_fail++;
        $display("FAIL rnd_valid@%0d: got %b want %b", m_cyc, l1_valid_o, m_valid);
      end
      if (l1_stall_o !== m_stall) begin
        n_fail++;
        $display("FAIL rnd_stall@%0d: got %b want %b", m_cyc, l1_stall_o, m_stall);
      end
      if (m_valid) begin
        n_tests++;
        if (l1_id_o !== m_id) begin
          n_fail++;
          $display("FAIL rnd_id@%0d: got %h want %h", m_cyc, l1_id_o, m_id);
        end
        if (m_known) begin
          n_tests++;
          if (l1_data_o !== m_data) begin
            n_fail++;
            $display("FAIL rnd_data@%0d: got %h want %h", m_cyc, l1_data_o, m_data);
          end
        end
      end
    end
    n_tests++;
    if (dut.r_drop_err !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drop: got %b want 0", dut.r_drop_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alias();
    test_overflow();
    test_simul();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
Name: l2_responder

Overview:
- Memory-side end of the L1 miss/writeback interface. Serves the L1 data cache's line-granular requests: line fills (read) and dirty-line writebacks (write).
- Accepts requests into an in-order request queue and applies back-pressure through a stall line.
- Serves each request from an internal line-wide backing store after a fixed access latency, and returns read lines tagged with the requester's MSHR id.
- Acts as the L2/memory model behind the L1 in system simulation, and as a synthesizable single-port L2 data store.

Parameters:
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: word width.
- WORDS, 8: words per line; line width = DATA_WIDTH*WORDS.
- LINE_BITS, 5: log2 of line size in bytes.
- MEM_INDEX_BITS, 10: log2 of backing-store lines.
- MSHR_ID_BITS, 4: request id width.
- QUEUE_DEPTH, 4: request queue entries; power of two, minimum 2.
- LATENCY, 4: access cycles per request; minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- l1_addr_i  in  ADDR_WIDTH  request byte address; low LINE_BITS ignored.
- l1_data_i  in  DATA_WIDTH*WORDS  writeback line.
- l1_rw_i  in  1  1 = write (writeback), 0 = read (fill).
- l1_valid_i  in  1  request strobe, one cycle per request.
- l1_id_i  in  MSHR_ID_BITS  requester MSHR id.
- l1_stall_o  out  1  queue almost full; L1 must not issue.
- l1_data_o  out  DATA_WIDTH*WORDS  returned fill line.
- l1_valid_o  out  1  one-cycle fill-return strobe.
- l1_id_o  out  MSHR_ID_BITS  id of returned fill.

Behaviour:
- Reset (async, active-low):
  - l1_valid_o=0, l1_data_o=0, l1_id_o=0, l1_stall_o=0.
  - Queue emptied, FSM to IDLE, latency counter 0.
  - Backing-store contents are not cleared.
  - A reset mid-access aborts that request: no response is ever produced and no write is committed.
- Acceptance:
  - A request is enqueued at any edge where l1_valid_i=1 and the queue is not full.
  - If the queue is full, the request is dropped and the simulation-only error flag/assertion fires.
- Stall:
  - l1_stall_o is registered and equals (occupancy >= QUEUE_DEPTH-1) after each edge. This gives one request of slack for the L1's registered stall sampling.
  - Enqueue and dequeue on the same edge leave occupancy unchanged.
- Line index: l1_addr_i[LINE_BITS+MEM_INDEX_BITS-1:LINE_BITS]. Higher address bits are ignored, so addresses alias modulo the store size.
- FSM IDLE:
  - If the queue is non-empty, pop the head into the active-request registers, load counter=LATENCY-1, and go to ACCESS.
  - A request arriving at an empty queue is not popped on the same edge it is enqueued.
- FSM ACCESS:
  - While counter!=0, decrement.
  - When counter==0: a write commits the line to the store; a read registers the store line into l1_data_o, l1_id_o<=id, l1_valid_o<=1. Then return to IDLE.
- Timing:
  - A request accepted at edge E0 into an empty queue with the FSM idle: pop at E1, read response visible after edge E1+LATENCY (LATENCY+1 cycles after acceptance).
  - Sustained throughput: one request per LATENCY+1 cycles.
- l1_valid_o is high for exactly one cycle per read. It returns to 0 the following edge; l1_data_o and l1_id_o hold their last values.
- Writes produce no response.
- Ordering:
  - Strictly in order; no read/write reordering.
  - A read queued after a write to the same line returns the written data.
- No response back-pressure: the L1 always sinks l1_valid_o.

Decomposition:
- Shared package holds:
  - Request field offsets and the RW_READ=0 / RW_WRITE=1 encodings.
  - The FSM state encoding (IDLE=0, ACCESS=1).
  - The line-width constant expression DATA_WIDTH*WORDS.
- One sub-module: l2_req_fifo.
  - Entry = {addr line index, rw, id, line data}, QUEUE_DEPTH entries.
  - Signals: push, pop, head, empty, full, occupancy.
  - Wrap-around via pointers of log2(QUEUE_DEPTH)+1 bits.
- Backing store: inferred single-port line-wide array in l2_responder.

Test Plan:
- Reset, then write id=2 addr 0x0000_0040 data {8 words 0x1111_0000..0x1111_0007} → no l1_valid_o. Then read id=9 addr 0x0000_0044 → after acceptance edge E0 (queue empty, FSM idle), l1_valid_o=1 exactly in the cycle after edge E0+LATENCY+1 (=E0+5 at LATENCY=4), l1_id_o=9, same data, high one cycle.
- Reads id=3 (line 0x80) and id=5 (line 0xA0) on consecutive cycles, both lines preloaded → responses in order 3 then 5, spaced exactly LATENCY+1=5 cycles apart.
- QUEUE_DEPTH=4, stall ignored, 5 back-to-back writes while FSM busy → l1_stall_o=1 after occupancy reaches 3; 5th request dropped, error flag set, occupancy never exceeds 4.
- Write to addr 0x0000_8040 (aliases line 2 at MEM_INDEX_BITS=10) then read addr 0x0000_0040 → read returns the aliased write data.
- Reset asserted during ACCESS of read id=7 with 2 more queued → outputs 0 immediately, no response for id=7 or queued ids after release, l1_stall_o=0.
- Simultaneous enqueue and head pop at occupancy 3 → occupancy stays 3, l1_stall_o stays 1, no request lost.
